// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the pipelined Wishbone memory slave.
// Holds the init FSM states, the byte-mask expander and index sizing.
package wb_mem_pkg;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  function automatic logic [63:0] sel_mask(input logic [7:0] sel);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  function automatic int idx_bits(input int addr_bits, input int data_width);
    return addr_bits - $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Synchronous single-port RAM with per-byte write enables.
// Read is read-first; contents set by the owner after reset.
module wb_mem_array #(
  parameter int    DW        = 64,
  parameter int    IW        = 3,
  parameter string INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic          i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [IW-1:0] i_idx,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [2**IW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_re) rdata_q <= mem_q[i_idx];
    for (int b = 0; b < DW/8; b++) begin
      if (i_we && i_be[b]) mem_q[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/wb_mem.sv
// Pipelined Wishbone memory slave with zero-fill init sequencer.
// Define WB_MEM_ERR_EN to answer read-only writes with err instead of ack.
module wb_mem
  import wb_mem_pkg::*;
#(
  parameter logic [63:0] MAPPED_ADDRESS = 64'h0,
  parameter int          ADDR_BITS      = 17,
  parameter int          DATA_WIDTH     = 64,
  parameter int          READ_LATENCY   = 1,
  parameter int          READ_ONLY      = 0,
  parameter string       INIT_FILE      = ""
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [63:0]             i_wb_adr,
  input  logic [DATA_WIDTH-1:0]   i_wb_dat,
  output logic [DATA_WIDTH-1:0]   o_wb_dat,
  input  logic                    i_wb_we,
  input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_cyc,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic                    o_wb_err,
  output logic                    o_hit
);

  localparam int SELW  = DATA_WIDTH / 8;
  localparam int OFFB  = $clog2(SELW);
  localparam int IW    = idx_bits(ADDR_BITS, DATA_WIDTH);
  localparam int DEPTH = 1 << IW;
  localparam int LAST  = READ_LATENCY - 1;
  localparam bit ZFILL = (INIT_FILE == "");
  localparam bit RO    = (READ_ONLY != 0);

`ifdef WB_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [63:0] off;
  logic        acc;
  logic        ro_err;

  assign off   = i_wb_adr - MAPPED_ADDRESS;
  assign o_hit = (i_wb_adr >= MAPPED_ADDRESS) &&
                 ((off >> ADDR_BITS) == 64'd0);

  state_e        state_q;
  logic [IW-1:0] cnt_q;
  logic          stall_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ZFILL ? S_INIT : S_READY;
      cnt_q   <= '0;
      stall_q <= ZFILL;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= S_READY;
            stall_q <= 1'b0;
          end
        end
        default: stall_q <= 1'b0;
      endcase
    end
  end

  assign o_wb_stall = stall_q;
  assign acc    = o_hit & i_wb_cyc & i_wb_stb & ~stall_q;
  assign ro_err = ERR_EN & RO & i_wb_we;

  logic                  init_w;
  logic                  arr_we;
  logic [SELW-1:0]       arr_be;
  logic [IW-1:0]         arr_idx;
  logic [DATA_WIDTH-1:0] arr_wd;
  logic [DATA_WIDTH-1:0] arr_rd;

  // The fill sequencer owns the RAM port while stalled.
  assign init_w  = (state_q == S_INIT);
  assign arr_we  = init_w | (acc & i_wb_we & ~RO);
  assign arr_be  = init_w ? '1 : i_wb_sel;
  assign arr_idx = init_w ? cnt_q : i_wb_adr[ADDR_BITS-1:OFFB];
  assign arr_wd  = init_w ? '0 : i_wb_dat;

  wb_mem_array #(
    .DW       (DATA_WIDTH),
    .IW       (IW),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .i_clk  (i_clk),
    .i_re   (acc),
    .i_we   (arr_we),
    .i_be   (arr_be),
    .i_idx  (arr_idx),
    .i_wdata(arr_wd),
    .o_rdata(arr_rd)
  );

  logic [READ_LATENCY-1:0]           v_q;
  logic [READ_LATENCY-1:0]           we_q;
  logic [READ_LATENCY-1:0]           er_q;
  logic [READ_LATENCY-1:0][SELW-1:0] sel_q;

  // Dropping cyc squashes everything still in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v_q   <= '0;
      we_q  <= '0;
      er_q  <= '0;
      sel_q <= '0;
    end else begin
      v_q   <= READ_LATENCY'({v_q & {READ_LATENCY{i_wb_cyc}}, acc});
      we_q  <= READ_LATENCY'({we_q, i_wb_we});
      er_q  <= READ_LATENCY'({er_q, ro_err});
      sel_q <= (READ_LATENCY*SELW)'({sel_q, i_wb_sel});
    end
  end

  logic [DATA_WIDTH-1:0] rd_w;

  if (READ_LATENCY > 1) begin : g_rd2
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) rd_q <= '0;
      else            rd_q <= arr_rd;
    end
    assign rd_w = rd_q;
  end else begin : g_rd1
    assign rd_w = arr_rd;
  end

  logic        resp;
  logic [63:0] m64;

  assign resp     = v_q[LAST] & i_wb_cyc;
  assign o_wb_ack = resp & ~er_q[LAST];
  assign o_wb_err = resp & er_q[LAST];
  assign m64      = sel_mask(8'(sel_q[LAST]));
  assign o_wb_dat = (o_wb_ack & ~we_q[LAST]) ?
                    (rd_w & m64[DATA_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_wb_mem.sv
// Randomised bench for wb_mem: RW instance (latency 2) against a
// queue-based model, plus a read-only instance (latency 1).
module tb_wb_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT = 2;

  logic [63:0] adr, wdat, rdat;
  logic        we, stb, cyc, ack, stall, err, hit;
  logic [7:0]  sel;

  logic [63:0] r_adr, r_wdat, r_rdat;
  logic        r_we, r_stb, r_cyc, r_ack, r_stall, r_err, r_hit;
  logic [7:0]  r_sel;

  wb_mem #(
    .MAPPED_ADDRESS(64'h0), .ADDR_BITS(6), .DATA_WIDTH(64),
    .READ_LATENCY(LAT), .READ_ONLY(0), .INIT_FILE("")
  ) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_adr(adr), .i_wb_dat(wdat),
    .o_wb_dat(rdat), .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb),
    .i_wb_cyc(cyc), .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_err(err),
    .o_hit(hit)
  );

  wb_mem #(
    .MAPPED_ADDRESS(64'h200), .ADDR_BITS(6), .DATA_WIDTH(64),
    .READ_LATENCY(1), .READ_ONLY(1), .INIT_FILE("")
  ) u_ro (
    .i_clk(clk), .i_reset_n(rst_n), .i_wb_adr(r_adr), .i_wb_dat(r_wdat),
    .o_wb_dat(r_rdat), .i_wb_we(r_we), .i_wb_sel(r_sel), .i_wb_stb(r_stb),
    .i_wb_cyc(r_cyc), .o_wb_ack(r_ack), .o_wb_stall(r_stall),
    .o_wb_err(r_err), .o_hit(r_hit)
  );

  int n_chk;
  int n_pass;
  int edge_n;

  typedef struct {
    int          due;
    logic [63:0] d;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem [8];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic step(input string t, input logic c, input logic s,
                      input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] sl);
    logic        inwin;
    int          ix;
    exp_t        e;
    logic [63:0] m;
    cyc = c; stb = s; we = w; adr = a; wdat = d; sel = sl;
    #1;
    inwin = (a < 64'd64);
    check({t, "_hit"}, hit, inwin);
    if (!c) begin
      q.delete();
      check({t, "_abort_ack"}, ack, 0);
    end
    if (c && s && inwin) begin
      ix = int'(a[5:3]);
      m  = bmask(sl);
      e.due = edge_n + LAT;
      if (w) begin
        mem[ix] = (mem[ix] & ~m) | (d & m);
        e.d = 64'h0;
      end else begin
        e.d = mem[ix] & m;
      end
      q.push_back(e);
    end
    @(posedge clk); edge_n++;
    @(negedge clk);
    check({t, "_err"}, err, 0);
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      check({t, "_ack"}, ack, 1);
      check({t, "_dat"}, rdat, e.d);
    end else begin
      check({t, "_ack"}, ack, 0);
      check({t, "_dat"}, rdat, 0);
    end
  endtask

  task automatic wait_init(input string t);
    int n = 0;
    while (stall && n < 100) begin
      @(posedge clk); edge_n++;
      @(negedge clk); n++;
    end
    check(t, n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; edge_n = 0;
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
    r_cyc = 0; r_stb = 0; r_we = 0; r_adr = 0; r_wdat = 0; r_sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_dat", rdat, 0);
    check("rst_stall", stall, 1);
    check("ro_rst_stall", r_stall, 1);
    rst_n = 1'b1;
    wait_init("fill_cycles");
    check("ro_fill_done", r_stall, 0);

    r_cyc = 1; r_stb = 1; r_we = 0; r_adr = 64'h238; r_sel = 8'hFF;
    #1;
    check("ro_hit", r_hit, 1);
    check("ro_ack_pre", r_ack, 0);
    @(posedge clk); @(negedge clk);
    check("ro_rd_ack", r_ack, 1);
    check("ro_rd_dat", r_rdat, 0);
    r_we = 1; r_adr = 64'h200; r_wdat = 64'hDEAD;
    @(posedge clk); @(negedge clk);
`ifdef WB_MEM_ERR_EN
    check("ro_wr_err", r_err, 1);
    check("ro_wr_ack", r_ack, 0);
`else
    check("ro_wr_err", r_err, 0);
    check("ro_wr_ack", r_ack, 1);
`endif
    check("ro_wr_dat", r_rdat, 0);
    r_we = 0;
    @(posedge clk); @(negedge clk);
    check("ro_rb_ack", r_ack, 1);
    check("ro_rb_dat", r_rdat, 0);
    r_adr = 64'h240;
    #1;
    check("ro_oow_hit", r_hit, 0);
    @(posedge clk); @(negedge clk);
    check("ro_oow_ack", r_ack, 0);
    r_cyc = 0; r_stb = 0;

    step("bw0", 1, 1, 1, 64'h10, 64'h1122334455667788, 8'hFF);
    step("bw1", 1, 1, 1, 64'h10, 64'h00000000AAAAAAAA, 8'h0F);
    step("br0", 1, 1, 0, 64'h10, 64'h0, 8'hFF);
    step("br1", 1, 1, 0, 64'h13, 64'h0, 8'h0C);
    step("idl", 1, 0, 0, 64'h0, 64'h0, 8'h0);
    step("idl", 1, 0, 0, 64'h0, 64'h0, 8'h0);

    step("raw_w", 1, 1, 1, 64'h18, 64'hCAFEF00D12345678, 8'hFF);
    step("raw_r", 1, 1, 0, 64'h18, 64'h0, 8'hFF);

    for (int i = 0; i < 4; i++)
      step("pw", 1, 1, 1, 64'(i * 8), 64'(i + 1) * 64'h0101010101010101, 8'hFF);
    for (int i = 0; i < 4; i++)
      step("pr", 1, 1, 0, 64'(i * 8), 64'h0, 8'hFF);
    repeat (3) step("pidl", 1, 0, 0, 64'h0, 64'h0, 8'h0);

    step("ab_r0", 1, 1, 0, 64'h0, 64'h0, 8'hFF);
    step("ab_r1", 1, 1, 0, 64'h8, 64'h0, 8'hFF);
    repeat (3) step("ab_drop", 0, 0, 0, 64'h0, 64'h0, 8'h0);

    step("oow_w", 1, 1, 1, 64'd64, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    step("oow_r", 1, 1, 0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 8'hFF);

    for (int i = 0; i < 300; i++)
      step("rnd", 1, ($urandom_range(0, 3) != 0), 1'($urandom()),
           64'($urandom_range(0, 79)), {$urandom(), $urandom()},
           8'($urandom()));
    for (int i = 0; i < 8; i++)
      step("rb", 1, 1, 0, 64'(i * 8), 64'h0, 8'hFF);
    repeat (2) step("rbidl", 1, 0, 0, 64'h0, 64'h0, 8'h0);

    step("mr_w", 1, 1, 1, 64'h10, 64'h5555AAAA5555AAAA, 8'hFF);
    step("mr_r0", 1, 1, 0, 64'h10, 64'h0, 8'hFF);
    step("mr_r1", 1, 1, 0, 64'h10, 64'h0, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("mr_ack", ack, 0);
    check("mr_dat", rdat, 0);
    check("mr_stall", stall, 1);
    q.delete();
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    stb = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("refill_cycles");
    step("rf_r", 1, 1, 0, 64'h10, 64'h0, 8'hFF);
    repeat (2) step("rfidl", 1, 0, 0, 64'h0, 64'h0, 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
